// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman link: command codes, io bit positions,
// code-table entry layout and small helpers for mask/length conversion.
package huff_pkg;

    localparam int unsigned NUM_SYMS = 3;
    localparam int unsigned CODE_W   = 3;
    localparam int unsigned CHAR_W   = 8;

    localparam int unsigned LEN_W    = $clog2(CODE_W + 1);
    localparam int unsigned SYM_W    = $clog2(NUM_SYMS);
    localparam int unsigned WCNT_W   = $clog2(2 * NUM_SYMS);
    localparam int unsigned IO_W     = 12;
    localparam int unsigned PAY_W    = 9;

    // io_in field positions
    localparam int unsigned IO_STROBE  = 11;
    localparam int unsigned IO_CMD_HI  = 10;
    localparam int unsigned IO_CMD_LO  = 9;
    localparam int unsigned PAY_MASK_HI = 5;
    localparam int unsigned PAY_MASK_LO = 3;
    localparam int unsigned PAY_VAL_HI  = 2;

    // io_out field positions
    localparam int unsigned IO_VALID   = 8;
    localparam int unsigned IO_ERR     = 9;
    localparam int unsigned IO_READY   = 10;
    localparam int unsigned IO_PENDING = 11;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_BIT  = 2'b01;
    localparam logic [1:0] CMD_CLR  = 2'b10;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_DEC  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CHAR_W-1:0] chr;
        logic [LEN_W-1:0]  len;
        logic [CODE_W-1:0] value;
    } entry_t;

    // Contiguous low-order masks 2^n-1 give length n; anything else is an unusable entry.
    function automatic logic [LEN_W-1:0] mask_to_len(input logic [CODE_W-1:0] mask);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int unsigned i = 1; i <= CODE_W; i++) begin
            if (mask == CODE_W'((32'd1 << i) - 32'd1)) begin
                n = LEN_W'(i);
            end
        end
        return n;
    endfunction

    function automatic logic [CODE_W-1:0] len_to_mask(input logic [LEN_W-1:0] len);
        return CODE_W'((32'd1 << len) - 32'd1);
    endfunction

endpackage

// File: rtl/huff_code_match.sv
// Combinational code lookup: finds the lowest-index table entry whose code equals
// the accumulated bits of the given length.
module huff_code_match
    import huff_pkg::*;
(
    input  logic [CODE_W-1:0]         nacc,
    input  logic [LEN_W-1:0]          nlen,
    input  entry_t [NUM_SYMS-1:0]     tbl,
    output logic                      hit_c,
    output logic [CHAR_W-1:0]         chr_c
);

    logic [CODE_W-1:0] len_mask;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_c    = 1'b0;
        chr_c    = '0;
        len_mask = len_to_mask(nlen);
        for (int i = NUM_SYMS - 1; i >= 0; i--) begin
            if ((nlen != '0) && (tbl[i].len == nlen) &&
                (((tbl[i].value ^ nacc) & len_mask) == '0)) begin
                hit_c = 1'b1;
                chr_c = tbl[i].chr;
            end
        end
    end

endmodule

// File: rtl/huff_decoder.sv
// Huffman receive side: loads the per-symbol code table from io_in, then decodes an
// MSB-first serial bitstream into characters reported on io_out.
module huff_decoder
    import huff_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [IO_W-1:0] io_in,
    output logic [IO_W-1:0] io_out
);

    state_t                 state_q, state_d;
    logic [WCNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic [CODE_W-1:0]      acc_q, acc_d;
    logic [LEN_W-1:0]       len_q, len_d;
    entry_t [NUM_SYMS-1:0]  tbl_q, tbl_d;
    logic [CHAR_W-1:0]      chr_q, chr_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   ready_q, ready_d;
    logic                   pending_q, pending_d;

    logic                   strobe_c;
    logic [1:0]             cmd_c;
    logic [PAY_W-1:0]       payload_c;
    logic [SYM_W-1:0]       sym_idx_c;
    logic [CODE_W-1:0]      nacc_c;
    logic [LEN_W-1:0]       nlen_c;
    logic                   hit_c;
    logic [CHAR_W-1:0]      hit_chr_c;
    logic                   unused_payload_c;

    assign strobe_c  = io_in[IO_STROBE];
    assign cmd_c     = io_in[IO_CMD_HI:IO_CMD_LO];
    assign payload_c = io_in[PAY_W-1:0];
    assign sym_idx_c = SYM_W'(word_cnt_q >> 1);
    assign nacc_c    = {acc_q[CODE_W-2:0], payload_c[0]};
    assign nlen_c    = LEN_W'(len_q + LEN_W'(1));
    assign unused_payload_c = payload_c[PAY_W-1];

    huff_code_match u_match (
        .nacc  (nacc_c),
        .nlen  (nlen_c),
        .tbl   (tbl_q),
        .hit_c (hit_c),
        .chr_c (hit_chr_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_LOAD;
            word_cnt_q <= '0;
            acc_q      <= '0;
            len_q      <= '0;
            tbl_q      <= '0;
            chr_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            acc_q      <= acc_d;
            len_q      <= len_d;
            tbl_q      <= tbl_d;
            chr_q      <= chr_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            pending_q  <= pending_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        acc_d      = acc_q;
        len_d      = len_q;
        tbl_d      = tbl_q;
        chr_d      = chr_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        ready_d    = ready_q;

        if (strobe_c) begin
            if (cmd_c == CMD_CLR) begin
                state_d    = S_LOAD;
                word_cnt_d = '0;
                acc_d      = '0;
                len_d      = '0;
                chr_d      = '0;
                err_d      = 1'b0;
                ready_d    = 1'b0;
                for (int i = 0; i < NUM_SYMS; i++) begin
                    tbl_d[i].len = '0;
                end
            end else begin
                unique case (state_q)
                    S_LOAD: begin
                        if (cmd_c == CMD_LOAD) begin
                            // Even words carry the character, odd words the mask/value pair.
                            if (!word_cnt_q[0]) begin
                                tbl_d[sym_idx_c].chr = payload_c[CHAR_W-1:0];
                            end else begin
                                tbl_d[sym_idx_c].len   = mask_to_len(payload_c[PAY_MASK_HI:PAY_MASK_LO]);
                                tbl_d[sym_idx_c].value = payload_c[PAY_VAL_HI:0];
                            end
                            word_cnt_d = WCNT_W'(word_cnt_q + WCNT_W'(1));
                            if (word_cnt_q == WCNT_W'(2 * NUM_SYMS - 1)) begin
                                state_d = S_DEC;
                                ready_d = 1'b1;
                            end
                        end
                    end
                    S_DEC: begin
                        if (cmd_c == CMD_BIT) begin
                            if (hit_c) begin
                                chr_d   = hit_chr_c;
                                valid_d = 1'b1;
                                acc_d   = '0;
                                len_d   = '0;
                            end else if (nlen_c == LEN_W'(CODE_W)) begin
                                state_d = S_ERR;
                                err_d   = 1'b1;
                                acc_d   = '0;
                                len_d   = '0;
                            end else begin
                                acc_d = nacc_c;
                                len_d = nlen_c;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        pending_d = (len_d != '0);
    end

    assign io_out = {pending_q, ready_q, err_q, valid_q, chr_q};

endmodule
